// File: rtl/axicb_wdata_steer.sv
// Write-data steering for an AXI crossbar slave port: queues address-channel grants
// in order and routes each granted requester's W burst to the target until WLAST.
module axicb_wdata_steer #(
   parameter int REQ_NB = 4,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     srst,
   input  logic                     gvalid,
   input  logic [REQ_NB-1:0]        grant,
   output logic                     gready,
   input  logic [REQ_NB-1:0]        s_wvalid,
   output logic [REQ_NB-1:0]        s_wready,
   input  logic [REQ_NB-1:0]        s_wlast,
   input  logic [REQ_NB*DATA_W-1:0] s_wdata,
   output logic                     m_wvalid,
   input  logic                     m_wready,
   output logic                     m_wlast,
   output logic [DATA_W-1:0]        m_wdata,
   output logic                     err
);

   localparam int IW = $clog2(REQ_NB);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0] mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic [IW-1:0] gidx;
   logic [IW-1:0] head;
   logic          onehot;
   logic          empty;
   logic          push;
   logic          pop;

   assign onehot = (grant != '0) && ((grant & (grant - REQ_NB'(1))) == '0);
   assign empty  = (count == '0);
   assign gready = (count < CW'(DEPTH));
   assign push   = gvalid && gready && onehot;
   assign head   = mem[rptr];
   assign pop    = !empty && m_wvalid && m_wready && m_wlast;

   always_comb begin
      gidx = '0;
      for (int unsigned i = 0; i < REQ_NB; i++) begin
         if (grant[i]) gidx = IW'(i);
      end
   end

   // Only the head requester sees m_wready; everything else is held off.
   always_comb begin
      m_wvalid = 1'b0;
      m_wlast  = 1'b0;
      m_wdata  = '0;
      s_wready = '0;
      for (int unsigned i = 0; i < REQ_NB; i++) begin
         if (!empty && (head == IW'(i))) begin
            m_wvalid    = s_wvalid[i];
            m_wlast     = s_wlast[i];
            m_wdata     = s_wdata[i*DATA_W +: DATA_W];
            s_wready[i] = m_wready;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (srst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (gvalid && gready && !onehot) err <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (push) mem[wptr] <= gidx;
   end

endmodule

// File: tb/tb_axicb_wdata_steer.sv
// Scoreboard bench for axicb_wdata_steer: a grant-order model plus per-requester
// burst drivers; expected beats are queued when bursts are planned.
module tb_axicb_wdata_steer;

   localparam int REQ_NB = 4;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 4;

   logic                     aclk = 1'b0;
   logic                     aresetn = 1'b0;
   logic                     srst = 1'b0;
   logic                     gvalid = 1'b0;
   logic [REQ_NB-1:0]        grant = '0;
   logic                     gready;
   logic [REQ_NB-1:0]        s_wvalid;
   logic [REQ_NB-1:0]        s_wready;
   logic [REQ_NB-1:0]        s_wlast;
   logic [REQ_NB*DATA_W-1:0] s_wdata;
   logic                     m_wvalid;
   logic                     m_wready = 1'b0;
   logic                     m_wlast;
   logic [DATA_W-1:0]        m_wdata;
   logic                     err;

   axicb_wdata_steer #(.REQ_NB(REQ_NB), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .gvalid(gvalid), .grant(grant),
      .gready(gready), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
      .s_wdata(s_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
      .m_wdata(m_wdata), .err(err)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int unsigned r;
      int unsigned n;
   } burst_t;

   int               n_cmp = 0;
   int               n_bad = 0;
   int               beats = 0;
   int unsigned      gq[$];
   logic [DATA_W:0]  expq[$];
   burst_t           bq[$];
   int unsigned      cur_left [REQ_NB];
   int unsigned      seq [REQ_NB];
   int unsigned      pseq [REQ_NB];
   logic [REQ_NB-1:0] rogue = '0;
   logic             err_m = 1'b0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      for (int unsigned r = 0; r < REQ_NB; r++) begin
         if (cur_left[r] == 0) begin
            for (int k = 0; k < bq.size(); k++) begin
               if (bq[k].r == r) begin
                  cur_left[r] = bq[k].n;
                  bq.delete(k);
                  break;
               end
            end
         end
         s_wvalid[r] = (cur_left[r] != 0) || rogue[r];
         s_wlast[r]  = (cur_left[r] == 1);
         s_wdata[r*DATA_W +: DATA_W] = {8'(r), 56'(seq[r])};
      end
   endtask

   task automatic plan(input int unsigned r, input int unsigned n);
      burst_t b;
      b.r = r;
      b.n = n;
      bq.push_back(b);
      for (int unsigned k = 0; k < n; k++)
         expq.push_back({1'(k == n - 1), 8'(r), 56'(pseq[r] + k)});
      pseq[r] += n;
      drive();
   endtask

   task automatic flush();
      gq.delete();
      expq.delete();
      bq.delete();
      for (int unsigned r = 0; r < REQ_NB; r++) begin
         cur_left[r] = 0;
         seq[r]      = pseq[r];
      end
      err_m = 1'b0;
   endtask

   // Model advances on the handshakes it expects, not on what the DUT reports.
   task automatic step();
      int unsigned       h;
      int unsigned       gi;
      logic              fire;
      logic              lastb;
      logic              pushed;
      logic              bad;
      logic [REQ_NB-1:0] g;
      @(posedge aclk);
      if (!aresetn || srst) begin
         flush();
         #1;
         drive();
         return;
      end
      fire  = 1'b0;
      lastb = 1'b0;
      h     = 0;
      if (gq.size() > 0) begin
         h     = gq[0];
         fire  = s_wvalid[h] && (cur_left[h] != 0) && m_wready;
         lastb = (cur_left[h] == 1);
      end
      g      = grant;
      gi     = 0;
      for (int unsigned i = 0; i < REQ_NB; i++) if (g[i]) gi = i;
      pushed = gvalid && (gq.size() < DEPTH) && $onehot(g);
      bad    = gvalid && (gq.size() < DEPTH) && !$onehot(g);
      #1;
      if (fire) begin
         seq[h]++;
         cur_left[h]--;
         if (lastb) void'(gq.pop_front());
      end
      if (pushed) gq.push_back(gi);
      if (bad) err_m = 1'b1;
      drive();
   endtask

   task automatic drain(input int unsigned budget, input bit toggle);
      int unsigned n = 0;
      while (expq.size() != 0 && n < budget) begin
         if (toggle) m_wready = ~m_wready;
         step();
         n++;
      end
      chk("drain_timeout", 128'(expq.size()), 128'(0));
   endtask

   always @(negedge aclk) begin
      logic [REQ_NB-1:0] exp_sw;
      logic              exp_mv;
      exp_sw = '0;
      exp_mv = 1'b0;
      if (gq.size() > 0) begin
         exp_mv = s_wvalid[gq[0]];
         if (m_wready) exp_sw[gq[0]] = 1'b1;
      end else begin
         chk("m_wdata_idle", 128'(m_wdata), 128'(0));
         chk("m_wlast_idle", 128'(m_wlast), 128'(0));
      end
      chk("s_wready", 128'(s_wready), 128'(exp_sw));
      chk("m_wvalid", 128'(m_wvalid), 128'(exp_mv));
      chk("gready", 128'(gready), 128'(gq.size() < DEPTH));
      chk("err", 128'(err), 128'(err_m));
      if (m_wvalid && m_wready) begin
         beats++;
         if (expq.size() == 0) chk("beat_unexpected", 128'(1), 128'(0));
         else chk("beat", 128'({m_wlast, m_wdata}), 128'(expq.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      int unsigned n;
      for (int unsigned r = 0; r < REQ_NB; r++) begin
         cur_left[r] = 0;
         seq[r]      = 0;
         pseq[r]     = 0;
      end
      drive();
      repeat (3) step();
      chk("rst_gready", 128'(gready), 128'(1));
      chk("rst_m_wvalid", 128'(m_wvalid), 128'(0));
      chk("rst_s_wready", 128'(s_wready), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      aresetn = 1'b1;
      repeat (2) step();

      // single 3-beat burst on requester 1
      m_wready = 1'b1;
      gvalid = 1'b1; grant = 4'b0010; plan(1, 3);
      step();
      gvalid = 1'b0;
      drain(20, 1'b0);
      step();
      chk("single_empty", 128'({gready, m_wvalid, s_wready}), 128'({1'b1, 1'b0, 4'b0000}));

      // push order req0, req2, req0 with back-to-back bursts
      b0 = beats;
      gvalid = 1'b1; grant = 4'b0001; plan(0, 2); step();
      grant = 4'b0100; plan(2, 2); step();
      grant = 4'b0001; plan(0, 2); step();
      gvalid = 1'b0;
      repeat (4) step();
      chk("order_no_idle", 128'(beats - b0), 128'(6));
      drain(10, 1'b0);
      step();

      // fill, ignored 5th grant, pop-while-full without bypass
      m_wready = 1'b0;
      gvalid = 1'b1;
      for (int unsigned r = 0; r < REQ_NB; r++) begin
         grant = 4'(1 << r);
         step();
      end
      grant = 4'b0001; step();
      chk("full_gready", 128'(gready), 128'(0));
      grant = 4'b1000; m_wready = 1'b1; plan(0, 1);
      step();
      gvalid = 1'b0;
      chk("gready_after_pop", 128'(gready), 128'(1));
      plan(1, 1); plan(2, 1); plan(3, 1);
      drain(20, 1'b0);
      repeat (2) step();

      // backpressure with stray valids on non-head requesters
      rogue = 4'b0101; drive();
      gvalid = 1'b1; grant = 4'b1000; plan(3, 5);
      step();
      gvalid = 1'b0;
      drain(40, 1'b1);
      rogue = '0; drive(); m_wready = 1'b1;
      repeat (2) step();

      // illegal grant, err sticky, occupancy unaffected, srst clears
      m_wready = 1'b0;
      gvalid = 1'b1; grant = 4'b0001; step();
      grant = 4'b0110; step();
      gvalid = 1'b0; step();
      chk("illegal_err", 128'(err), 128'(1));
      step();
      chk("illegal_err_held", 128'(err), 128'(1));
      gvalid = 1'b1;
      grant = 4'b0010; step();
      grant = 4'b0100; step();
      grant = 4'b1000; step();
      gvalid = 1'b0; step();
      chk("illegal_count", 128'(gready), 128'(0));
      srst = 1'b1; step();
      srst = 1'b0; step();
      chk("srst_err", 128'(err), 128'(0));
      chk("srst_gready", 128'(gready), 128'(1));

      // async reset mid-burst
      m_wready = 1'b1;
      gvalid = 1'b1; grant = 4'b0100; plan(2, 4);
      step();
      gvalid = 1'b0;
      b0 = beats;
      n = 0;
      while (beats - b0 < 1 && n < 10) begin
         step();
         n++;
      end
      chk("midburst_first_beat", 128'(beats - b0 >= 1), 128'(1));
      rogue = 4'b0100;
      aresetn = 1'b0;
      flush();
      drive();
      #1;
      chk("arst_m_wvalid", 128'(m_wvalid), 128'(0));
      chk("arst_gready", 128'(gready), 128'(1));
      chk("arst_s_wready", 128'(s_wready), 128'(0));
      repeat (2) step();
      aresetn = 1'b1;
      rogue = 4'b1111; drive();
      repeat (5) step();
      chk("post_rst_no_accept", 128'(s_wready), 128'(0));
      chk("post_rst_no_mwvalid", 128'(m_wvalid), 128'(0));
      rogue = '0; drive();
      gvalid = 1'b1; grant = 4'b0010; plan(1, 2);
      step();
      gvalid = 1'b0;
      drain(20, 1'b0);
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
